// File: rtl/chess_input_pkg.sv
// Shared key codes, FSM states and event encoding for the chess cursor input path.
package chess_input_pkg;
  localparam int SQ_W = 6;

  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;

  // Bit positions in the one-hot event vector; arrows occupy [3:0].
  localparam int EV_RIGHT = 0;
  localparam int EV_LEFT  = 1;
  localparam int EV_DOWN  = 2;
  localparam int EV_UP    = 3;
  localparam int EV_ENTER = 4;
  localparam int EV_ESC   = 5;
  localparam int NUM_EV   = 6;

  typedef enum logic [1:0] {IDLE, FROM_SEL, EMIT} state_t;

  function automatic logic [NUM_EV-1:0] key_onehot(input logic [7:0] code);
    logic [NUM_EV-1:0] oh;
    oh = '0;
    case (code)
      KEY_RIGHT: oh[EV_RIGHT] = 1'b1;
      KEY_LEFT:  oh[EV_LEFT]  = 1'b1;
      KEY_DOWN:  oh[EV_DOWN]  = 1'b1;
      KEY_UP:    oh[EV_UP]    = 1'b1;
      KEY_ENTER: oh[EV_ENTER] = 1'b1;
      KEY_ESC:   oh[EV_ESC]   = 1'b1;
      default:   oh = '0;
    endcase
    return oh;
  endfunction
endpackage

// File: rtl/keycode_press_detect.sv
// Registers the keycode word twice and turns new key appearances into a single
// prioritised one-hot event, plus which arrows are currently held.
module keycode_press_detect
  import chess_input_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_keycode,
  output logic [NUM_EV-1:0] o_evt,
  output logic [3:0]        o_present
);
  logic [15:0]       r_kc_q, r_kc_prev;
  logic [NUM_EV-1:0] w_lo_oh, w_hi_oh, w_prev_oh, w_press_lo, w_press_hi, w_press;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_kc_q    <= '0;
      r_kc_prev <= '0;
    end else begin
      r_kc_q    <= i_keycode;
      r_kc_prev <= r_kc_q;
    end
  end

  assign w_lo_oh    = key_onehot(r_kc_q[7:0]);
  assign w_hi_oh    = key_onehot(r_kc_q[15:8]);
  assign w_prev_oh  = key_onehot(r_kc_prev[7:0]) | key_onehot(r_kc_prev[15:8]);
  assign w_press_lo = w_lo_oh & ~w_prev_oh;
  assign w_press_hi = w_hi_oh & ~w_prev_oh;
  assign w_press    = w_press_lo | w_press_hi;
  assign o_present  = w_lo_oh[3:0] | w_hi_oh[3:0];

  // Escape beats Enter beats arrows; a new arrow in the low byte beats the high byte.
  always_comb begin
    o_evt = '0;
    if (w_press[EV_ESC])          o_evt[EV_ESC]   = 1'b1;
    else if (w_press[EV_ENTER])   o_evt[EV_ENTER] = 1'b1;
    else if (|w_press_lo[3:0])    o_evt[3:0]      = w_press_lo[3:0];
    else                          o_evt[3:0]      = w_press_hi[3:0];
  end
endmodule

// File: rtl/chess_cursor_ctrl.sv
// Keyboard-driven board cursor with from/to square selection, arrow auto-repeat,
// and a valid/ready move output toward game logic.
module chess_cursor_ctrl
  import chess_input_pkg::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic [15:0]     keycode_export,
  output logic [2:0]      cursor_x,
  output logic [2:0]      cursor_y,
  output logic            sel_valid,
  output logic [SQ_W-1:0] sel_sq,
  output logic            move_valid,
  output logic [SQ_W-1:0] move_from,
  output logic [SQ_W-1:0] move_to,
  input  logic            move_ready
);
  localparam int CNT_MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W    = $clog2(CNT_MAXV + 1);
  localparam logic [CNT_W-1:0] DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PER = CNT_W'(REPEAT_PERIOD);

  logic [NUM_EV-1:0] w_evt;
  logic [3:0]        w_present, w_arrow;
  logic              w_active, w_accept, w_held_on, w_repeat;
  logic [CNT_W-1:0]  w_cnt_nxt, w_target;

  state_t            r_state;
  logic [3:0]        r_held;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rep;
  logic [2:0]        r_x, r_y;
  logic              r_sel_valid, r_move_valid;
  logic [SQ_W-1:0]   r_sel_sq, r_move_from, r_move_to;

  keycode_press_detect u_press (
    .i_clk     (clk_clk),
    .i_rst_n   (reset_reset_n),
    .i_keycode (keycode_export),
    .o_evt     (w_evt),
    .o_present (w_present)
  );

  assign w_active  = (r_state != EMIT);
  assign w_accept  = w_active && (|w_evt);
  assign w_held_on = |(r_held & w_present);
  assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_target  = r_rep ? PER : DLY;
  assign w_repeat  = w_active && !w_accept && w_held_on && (w_cnt_nxt == w_target);
  assign w_arrow   = w_accept ? w_evt[3:0] : (w_repeat ? r_held : 4'b0);

  // Held key tracking: a non-arrow event loads an all-zero held mask, dropping it.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || !w_active) begin
      r_held <= '0;
      r_cnt  <= '0;
      r_rep  <= 1'b0;
    end else if (w_accept) begin
      r_held <= w_evt[3:0];
      r_cnt  <= '0;
      r_rep  <= 1'b0;
    end else if (!w_held_on) begin
      r_held <= '0;
      r_cnt  <= '0;
      r_rep  <= 1'b0;
    end else if (w_repeat) begin
      r_cnt  <= '0;
      r_rep  <= 1'b1;
    end else begin
      r_cnt  <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_sel_valid  <= 1'b0;
      r_sel_sq     <= '0;
      r_move_valid <= 1'b0;
      r_move_from  <= '0;
      r_move_to    <= '0;
    end else begin
      if (w_arrow[EV_RIGHT] && r_x != 3'd7) r_x <= r_x + 3'd1;
      if (w_arrow[EV_LEFT]  && r_x != 3'd0) r_x <= r_x - 3'd1;
      if (w_arrow[EV_DOWN]  && r_y != 3'd7) r_y <= r_y + 3'd1;
      if (w_arrow[EV_UP]    && r_y != 3'd0) r_y <= r_y - 3'd1;
      unique case (r_state)
        IDLE: begin
          if (w_evt[EV_ENTER]) begin
            r_sel_sq    <= {r_y, r_x};
            r_sel_valid <= 1'b1;
            r_state     <= FROM_SEL;
          end
        end
        FROM_SEL: begin
          if (w_evt[EV_ESC]) begin
            r_sel_valid <= 1'b0;
            r_state     <= IDLE;
          end else if (w_evt[EV_ENTER]) begin
            if ({r_y, r_x} == r_sel_sq) begin
              r_sel_valid <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_move_from  <= r_sel_sq;
              r_move_to    <= {r_y, r_x};
              r_move_valid <= 1'b1;
              r_state      <= EMIT;
            end
          end
        end
        EMIT: begin
          if (r_move_valid && move_ready) begin
            r_move_valid <= 1'b0;
            r_sel_valid  <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cursor_x   = r_x;
  assign cursor_y   = r_y;
  assign sel_valid  = r_sel_valid;
  assign sel_sq     = r_sel_sq;
  assign move_valid = r_move_valid;
  assign move_from  = r_move_from;
  assign move_to    = r_move_to;
endmodule

// File: tb/tb_chess_cursor_ctrl.sv
// Directed, table-driven bench for chess_cursor_ctrl with short repeat timing.
module tb_chess_cursor_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] kc = '0;
  logic        ready = 1'b0;
  logic [2:0]  cx, cy;
  logic        sv, mv;
  logic [5:0]  ssq, mf, mt;

  chess_cursor_ctrl #(.REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .keycode_export (kc),
    .cursor_x       (cx),
    .cursor_y       (cy),
    .sel_valid      (sv),
    .sel_sq         (ssq),
    .move_valid     (mv),
    .move_from      (mf),
    .move_to        (mt),
    .move_ready     (ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] kc;
    logic [2:0]  x, y;
    logic        sv;
    logic [5:0]  sq;
    logic        mv;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [15:0] code);
    kc = code;
    tick; tick;
    kc = '0;
    tick; tick;
  endtask

  task automatic add(input logic [15:0] k, input logic [2:0] x, input logic [2:0] y,
                     input logic s, input logic [5:0] q, input logic m);
    vec_t v;
    v.kc = k; v.x = x; v.y = y; v.sv = s; v.sq = q; v.mv = m;
    tbl.push_back(v);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      press(tbl[i].kc);
      chk($sformatf("row%0d x", i),  16'(cx),  16'(tbl[i].x));
      chk($sformatf("row%0d y", i),  16'(cy),  16'(tbl[i].y));
      chk($sformatf("row%0d sv", i), 16'(sv),  16'(tbl[i].sv));
      chk($sformatf("row%0d sq", i), 16'(ssq), 16'(tbl[i].sq));
      chk($sformatf("row%0d mv", i), 16'(mv),  16'(tbl[i].mv));
    end
  endtask

  logic [2:0]  rep_exp [12] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5};
  logic [15:0] bp_codes [10] = '{16'h0050, 16'h0000, 16'h0028, 16'h0000, 16'h0051,
                                 16'h0000, 16'h4F52, 16'h0000, 16'h0029, 16'h0000};

  initial begin
    // Phase A: saturation, walk to (4,6), select and build a move
    add(16'h0052, 0, 0, 0, 6'h00, 0);
    for (int i = 0; i < 3; i++) add(16'h0050, 0, 0, 0, 6'h00, 0);
    for (int i = 0; i < 2; i++) add(16'h0052, 0, 0, 0, 6'h00, 0);
    for (int i = 1; i <= 9; i++) add(16'h004F, (i > 7) ? 3'd7 : 3'(i), 0, 0, 6'h00, 0);
    for (int i = 1; i <= 3; i++) add(16'h0050, 3'(7 - i), 0, 0, 6'h00, 0);
    for (int i = 1; i <= 6; i++) add(16'h0051, 4, 3'(i), 0, 6'h00, 0);
    add(16'h0028, 4, 6, 1, 6'h34, 0);
    add(16'h0052, 4, 5, 1, 6'h34, 0);
    add(16'h0052, 4, 4, 1, 6'h34, 0);
    add(16'h0028, 4, 4, 1, 6'h34, 1);               // row 27
    // Phase B: cancel paths and simultaneous keys
    add(16'h0028, 4, 4, 1, 6'h24, 0);               // row 28
    add(16'h0029, 4, 4, 0, 6'h24, 0);
    add(16'h0028, 4, 4, 1, 6'h24, 0);
    add(16'h0028, 4, 4, 0, 6'h24, 0);
    add(16'h4F52, 4, 3, 0, 6'h24, 0);
    add(16'h0028, 4, 3, 1, 6'h1C, 0);
    add(16'h2952, 4, 3, 0, 6'h1C, 0);
    for (int i = 1; i <= 4; i++) add(16'h0050, 3'(4 - i), 3, 0, 6'h1C, 0);  // rows 35..38

    // Reset held with Down on the keycode input
    rst_n = 1'b0;
    kc = 16'h0051;
    tick; tick; tick;
    chk("rst x", 16'(cx), 16'h0);
    chk("rst y", 16'(cy), 16'h0);
    chk("rst sv", 16'(sv), 16'h0);
    chk("rst mv", 16'(mv), 16'h0);
    rst_n = 1'b1;
    tick;
    chk("rst+1 y", 16'(cy), 16'h0);
    tick;
    chk("rst+2 y", 16'(cy), 16'h1);
    kc = '0;
    tick; tick;

    run_rows(0, 27);
    chk("move_from", 16'(mf), 16'h34);
    chk("move_to",   16'(mt), 16'h24);

    // Backpressure: keys during EMIT must not change anything
    for (int i = 0; i < 10; i++) begin
      kc = bp_codes[i];
      tick;
      chk($sformatf("bp%0d x", i),  16'(cx), 16'h4);
      chk($sformatf("bp%0d y", i),  16'(cy), 16'h4);
      chk($sformatf("bp%0d mv", i), 16'(mv), 16'h1);
      chk($sformatf("bp%0d mf", i), 16'(mf), 16'h34);
      chk($sformatf("bp%0d mt", i), 16'(mt), 16'h24);
    end
    kc = '0;
    tick; tick;
    ready = 1'b1;
    tick;
    chk("hs mv", 16'(mv), 16'h0);
    chk("hs sv", 16'(sv), 16'h0);
    ready = 1'b0;
    tick;
    chk("hs+1 mv", 16'(mv), 16'h0);
    chk("hs x", 16'(cx), 16'h4);
    chk("hs y", 16'(cy), 16'h4);

    run_rows(28, 38);

    // Auto-repeat: Right held 12 cycles from x=0
    kc = 16'h004F;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk($sformatf("rep%0d x", i), 16'(cx), 16'(rep_exp[i]));
    end
    kc = '0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("rel%0d x", i), 16'(cx), 16'h5);
    end

    // Reset in the middle of an offered move
    press(16'h0028);
    chk("pre sq", 16'(ssq), 16'h1D);
    press(16'h0050);
    press(16'h0028);
    chk("pre mv", 16'(mv), 16'h1);
    chk("pre mt", 16'(mt), 16'h1C);
    rst_n = 1'b0;
    tick;
    chk("mid x",  16'(cx),  16'h0);
    chk("mid y",  16'(cy),  16'h0);
    chk("mid sv", 16'(sv),  16'h0);
    chk("mid sq", 16'(ssq), 16'h0);
    chk("mid mv", 16'(mv),  16'h0);
    chk("mid mf", 16'(mf),  16'h0);
    chk("mid mt", 16'(mt),  16'h0);
    rst_n = 1'b1;
    tick; tick;
    chk("post mv", 16'(mv), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
